// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fib_pkg
//  Description : Shared types and reference model for the recurrence stream
//                generator (state encoding, {carry,term} reference function).
//  Revision    : 1.0  initial release
// ============================================================================
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reference term(k) for seeds seed0/seed1 at arithmetic width w (1..64).
  // Returns {carry, term}: carry is the carry-out of the addition that
  // produced term(k) from the wrapped terms k-1 and k-2 (0 for k <= 2).
  function automatic logic [64:0] fib_ref(input logic [63:0] seed0,
                                          input logic [63:0] seed1,
                                          input int          k,
                                          input int          w);
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] s;
    logic        c;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = seed0 & mask;
    b    = seed1 & mask;
    c    = 1'b0;
    s    = '0;
    if (k <= 1) return {1'b0, a};
    for (int i = 3; i <= k; i++) begin
      s = {1'b0, a} + {1'b0, b};
      c = (w >= 64) ? s[64] : s[w];
      a = b;
      b = s[63:0] & mask;
    end
    return {c, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_term_adder.sv
`default_nettype none
// ============================================================================
//  Module      : fib_term_adder
//  Description : Combinational adder forming the next recurrence term with
//                its carry-out (used for overflow detection).
//  Revision    : 1.0  initial release
// ============================================================================
module fib_term_adder
  import fib_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic [OUTPUT_WIDTH-1:0] a_i,
  input  logic [OUTPUT_WIDTH-1:0] b_i,
  output logic [OUTPUT_WIDTH-1:0] sum_o,
  output logic                    carry_o
);

  // Widen by one bit so the carry-out falls out of the same addition.
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule
`default_nettype wire

// File: rtl/fib_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fib_stream
//  Description : Programmable-seed second-order recurrence generator. Streams
//                term(1..n) over a valid/ready port, then holds term(n) on
//                result with done high. Sticky per-run overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fib_stream
  import fib_pkg::*;
#(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    abort,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  output logic                    term_valid,
  input  logic                    term_ready,
  output logic [OUTPUT_WIDTH-1:0] term,
  output logic [INPUT_WIDTH-1:0]  term_index,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  state_t                  state_q;
  logic [INPUT_WIDTH-1:0]  n_q;
  logic [INPUT_WIDTH-1:0]  idx_q;
  logic [OUTPUT_WIDTH-1:0] x_q;       // current term (on the port)
  logic [OUTPUT_WIDTH-1:0] y_q;       // following term
  logic [OUTPUT_WIDTH-1:0] result_q;
  logic                    overflow_q;
  logic                    term_valid_q;
  logic                    busy_q;
  logic                    done_q;

  logic [OUTPUT_WIDTH-1:0] sum_d;
  logic                    carry_d;
  logic [INPUT_WIDTH-1:0]  idx_d;
  logic [INPUT_WIDTH:0]    idx_plus2_d;
  logic                    handshake_d;

  fib_term_adder #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_adder (
    .a_i     (x_q),
    .b_i     (y_q),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

  // Index arithmetic: idx_plus2 is one bit wider so k+2 never wraps at n=2**IW-1.
  assign idx_d       = idx_q + {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
  assign idx_plus2_d = {1'b0, idx_q} + {{(INPUT_WIDTH-1){1'b0}}, 2'd2};
  assign handshake_d = term_valid_q & term_ready;

  // Run control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      term_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            n_q        <= n;
            x_q        <= seed0;
            y_q        <= seed1;
            idx_q      <= {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
            overflow_q <= 1'b0;
            if (n == '0) begin
              // Empty run completes at once with a zero result.
              state_q  <= DONE;
              result_q <= '0;
              done_q   <= 1'b1;
            end else begin
              state_q      <= EMIT;
              term_valid_q <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (abort) begin
            // Cancel wins over any handshake or go in the same cycle.
            state_q      <= IDLE;
            term_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
          end else if (handshake_d) begin
            if (idx_q == n_q) begin
              state_q      <= DONE;
              result_q     <= x_q;
              term_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              x_q   <= y_q;
              y_q   <= sum_d;
              idx_q <= idx_d;
              // The sum just formed is term k+2; only count it if it is emitted.
              if (carry_d && (idx_plus2_d <= {1'b0, n_q})) begin
                overflow_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          term_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign term_valid = term_valid_q;
  assign term       = x_q;
  assign term_index = idx_q;
  assign result     = result_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_stream
//  Description : Self-checking bench for fib_stream: table of runs with a term
//                scoreboard, plus stall, abort and mid-run reset sequences.
//                A 32-bit and an 8-bit instance share all stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fib_stream;
  import fib_pkg::*;

  localparam int IW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          go;
  logic          abort;
  logic          term_ready;
  logic [IW-1:0] n;
  logic [31:0]   seed0;
  logic [31:0]   seed1;

  logic          tv32, ov32, b32, d32;
  logic [31:0]   t32, r32;
  logic [IW-1:0] ti32;
  logic          tv8, ov8, b8, d8;
  logic [7:0]    t8, r8;
  logic [IW-1:0] ti8;

  fib_stream #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .n(n),
    .seed0(seed0), .seed1(seed1),
    .term_valid(tv32), .term_ready(term_ready), .term(t32), .term_index(ti32),
    .result(r32), .overflow(ov32), .busy(b32), .done(d32)
  );

  fib_stream #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .n(n),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]),
    .term_valid(tv8), .term_ready(term_ready), .term(t8), .term_index(ti8),
    .result(r8), .overflow(ov8), .busy(b8), .done(d8)
  );

  // Selected instance view
  logic          sel8;
  logic          m_tv, m_ov, m_busy, m_done;
  logic [31:0]   m_t, m_r;
  logic [IW-1:0] m_ti;
  always_comb begin
    m_tv   = sel8 ? tv8 : tv32;
    m_t    = sel8 ? {24'd0, t8} : t32;
    m_ti   = sel8 ? ti8 : ti32;
    m_r    = sel8 ? {24'd0, r8} : r32;
    m_ov   = sel8 ? ov8 : ov32;
    m_busy = sel8 ? b8 : b32;
    m_done = sel8 ? d8 : d32;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0]   term;
    logic [IW-1:0] idx;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && m_tv) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_term: got index %0d value %0d, expected no term", m_ti, m_t);
      end else if (term_ready) begin
        mon_e = q.pop_front();
        check("term_value", {32'd0, m_t}, {32'd0, mon_e.term});
        check("term_index", {58'd0, m_ti}, {58'd0, mon_e.idx});
      end
    end
  end

  // Protocol properties on the 32-bit instance
  a_stable: assert property (@(posedge clk) disable iff (rst)
      (tv32 && !term_ready && !abort) |=> (tv32 && $stable(t32) && $stable(ti32)))
    else $error("FAIL assert_handshake_stable");
  a_done_busy: assert property (@(posedge clk) disable iff (rst) d32 |-> !b32)
    else $error("FAIL assert_done_not_busy");
  a_index_inc: assert property (@(posedge clk) disable iff (rst)
      (tv32 && term_ready && !abort) |=> (!tv32 || ti32 == $past(ti32) + 6'd1))
    else $error("FAIL assert_index_increment");

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive go for one accepting edge and queue the expected stream.
  task automatic start_run(input logic [IW-1:0] nn, input logic [31:0] s0,
                           input logic [31:0] s1, input bit w8);
    logic [64:0] rv;
    exp_t        e;
    sel8  = w8;
    n     = nn;
    seed0 = s0;
    seed1 = s1;
    for (int k = 1; k <= int'(nn); k++) begin
      rv     = fib_ref({32'd0, s0}, {32'd0, s1}, k, w8 ? 8 : 32);
      e.term = rv[31:0];
      e.idx  = IW'(k);
      q.push_back(e);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit stall);
    int cnt;
    cnt = 0;
    while (!m_done && cnt < budget) begin
      tick();
      term_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cnt++;
    end
    term_ready = 1'b1;
    if (!m_done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got timeout after %0d cycles, expected done", budget);
    end
  endtask

  task automatic wait_index(input logic [IW-1:0] target, input int budget);
    int cnt;
    cnt = 0;
    while (!(m_tv && m_ti == target) && cnt < budget) begin
      tick();
      cnt++;
    end
    if (!(m_tv && m_ti == target)) begin
      total++;
      bad++;
      $display("FAIL wait_index: got index %0d, expected %0d", m_ti, target);
    end
  endtask

  typedef struct {
    logic [31:0]   s0;
    logic [31:0]   s1;
    logic [IW-1:0] n;
    bit            w8;
    bit            stall;
    logic [31:0]   res;
    bit            ov;
  } row_t;
  row_t tbl[11];

  initial begin
    tbl[0]  = '{32'd0, 32'd1, 6'd10, 1'b0, 1'b0, 32'd34,         1'b0};
    tbl[1]  = '{32'd0, 32'd1, 6'd10, 1'b0, 1'b1, 32'd34,         1'b0};
    tbl[2]  = '{32'd7, 32'd9, 6'd1,  1'b0, 1'b0, 32'd7,          1'b0};
    tbl[3]  = '{32'd7, 32'd9, 6'd2,  1'b0, 1'b1, 32'd9,          1'b0};
    tbl[4]  = '{32'd0, 32'd1, 6'd0,  1'b0, 1'b0, 32'd0,          1'b0};
    tbl[5]  = '{32'd0, 32'd1, 6'd63, 1'b0, 1'b1, 32'd2585377753, 1'b1};
    tbl[6]  = '{32'd0, 32'd1, 6'd14, 1'b1, 1'b0, 32'd233,        1'b0};
    tbl[7]  = '{32'd0, 32'd1, 6'd15, 1'b1, 1'b1, 32'd121,        1'b1};
    tbl[8]  = '{32'd0, 32'd1, 6'd3,  1'b1, 1'b0, 32'd1,          1'b0};
    tbl[9]  = '{32'd0, 32'd1, 6'd63, 1'b1, 1'b1, 32'd217,        1'b1};
    tbl[10] = '{32'd2, 32'd1, 6'd5,  1'b0, 1'b0, 32'd7,          1'b0};

    rst        = 1'b1;
    go         = 1'b0;
    abort      = 1'b0;
    term_ready = 1'b1;
    n          = '0;
    seed0      = '0;
    seed1      = '0;
    sel8       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_term_valid", {63'd0, tv32}, 64'd0);
    check("rst_result",     {32'd0, r32},  64'd0);
    check("rst_done_busy",  {62'd0, d32, b32}, 64'd0);
    check("rst_ovf_idx",    {57'd0, ov32, ti32}, 64'd0);
    rst = 1'b0;
    tick();

    // Table of complete runs
    for (int i = 0; i < 11; i++) begin
      start_run(tbl[i].n, tbl[i].s0, tbl[i].s1, tbl[i].w8);
      if (tbl[i].n == '0) begin
        check("n0_done_next_cycle", {63'd0, m_done}, 64'd1);
        check("n0_no_valid",        {63'd0, m_tv},   64'd0);
      end else begin
        check("first_valid", {63'd0, m_tv}, 64'd1);
      end
      term_ready = tbl[i].stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wait_done(1000, tbl[i].stall);
      check("result",    {32'd0, m_r},  {32'd0, tbl[i].res});
      check("overflow",  {63'd0, m_ov}, {63'd0, tbl[i].ov});
      check("done_idle", {62'd0, m_done, m_busy}, 64'd2);
      check("stream_complete", 64'(q.size()), 64'd0);
      q.delete();
      tick();
    end

    // Lucas stream with a three-cycle stall on term 3
    start_run(6'd5, 32'd2, 32'd1, 1'b0);
    check("lucas_first_term", {32'd0, m_t}, 64'd2);
    wait_index(6'd3, 20);
    term_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_hold_valid", {63'd0, m_tv}, 64'd1);
      check("stall_hold_term",  {32'd0, m_t},  64'd3);
      check("stall_hold_index", {58'd0, m_ti}, 64'd3);
    end
    term_ready = 1'b1;
    wait_done(50, 1'b0);
    check("lucas_result", {32'd0, m_r}, 64'd7);
    check("lucas_stream_complete", 64'(q.size()), 64'd0);
    q.delete();
    tick();

    // go ignored during the run, abort at term 8
    start_run(6'd20, 32'd0, 32'd1, 1'b0);
    wait_index(6'd5, 20);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_ignored_busy",  {63'd0, m_busy}, 64'd1);
    check("go_ignored_index", {58'd0, m_ti},   64'd6);
    wait_index(6'd8, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid",    {63'd0, m_tv},   64'd0);
    check("abort_done",     {63'd0, m_done}, 64'd0);
    check("abort_busy",     {63'd0, m_busy}, 64'd0);
    check("abort_result",   {32'd0, m_r},    64'd7);
    check("abort_overflow", {63'd0, m_ov},   64'd0);
    q.delete();
    tick();
    tick();
    check("abort_stays_idle", {63'd0, m_tv}, 64'd0);
    start_run(6'd4, 32'd0, 32'd1, 1'b0);
    wait_done(50, 1'b0);
    check("after_abort_result", {32'd0, m_r}, 64'd2);
    check("after_abort_stream_complete", 64'(q.size()), 64'd0);
    q.delete();
    tick();

    // Asynchronous reset in the middle of a run
    start_run(6'd20, 32'd0, 32'd1, 1'b0);
    wait_index(6'd6, 20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid",  {63'd0, tv32}, 64'd0);
    check("midrst_term",   {32'd0, t32},  64'd0);
    check("midrst_index",  {58'd0, ti32}, 64'd0);
    check("midrst_result", {32'd0, r32},  64'd0);
    check("midrst_flags",  {61'd0, ov32, b32, d32}, 64'd0);
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("no_term_after_reset", {63'd0, tv32}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
